// File: rtl/nonrestoring_div_seq_pkg.sv
// rtl/nonrestoring_div_seq_pkg.sv - shared ALU width default and divider state encoding
package nonrestoring_div_seq_pkg;

    localparam int ALU_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/nonrestoring_div_seq_abs_sign.sv
// rtl/nonrestoring_div_seq_abs_sign.sv - two's-complement conditional negate (absolute value / sign apply)
module div_abs_sign #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_value,
    input  logic             i_negate,
    output logic [WIDTH-1:0] o_value
);

    // Result is read as unsigned, so -MIN_INT yields 2^(WIDTH-1) rather than overflowing.
    assign o_value = i_negate ? ((~i_value) + WIDTH'(1)) : i_value;

endmodule

// File: rtl/nonrestoring_div_seq.sv
// rtl/nonrestoring_div_seq.sv - multi-cycle signed non-restoring divider (quotient to LO, remainder to HI)
module nonrestoring_div_seq
    import nonrestoring_div_seq_pkg::*;
#(
    parameter int DATA_WIDTH = ALU_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder,
    output logic                  div_by_zero
);

    localparam int CW = $clog2(DATA_WIDTH);

    div_state_e r_state;
    div_state_e w_next;

    logic [DATA_WIDTH:0]   r_p;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_d;
    logic [CW-1:0]         r_cnt;
    logic                  r_sign_q;
    logic                  r_sign_r;

    logic                  w_div_zero;
    logic [DATA_WIDTH-1:0] w_abs_n;
    logic [DATA_WIDTH-1:0] w_abs_d;
    logic [DATA_WIDTH:0]   w_d_ext;
    logic [DATA_WIDTH:0]   w_p_shift;
    logic [DATA_WIDTH:0]   w_p_step;
    logic [DATA_WIDTH-1:0] w_a_step;
    logic [DATA_WIDTH-1:0] w_p_fix;
    logic [DATA_WIDTH-1:0] w_q_signed;
    logic [DATA_WIDTH-1:0] w_r_signed;

    assign w_div_zero = (divisor == '0);

    div_abs_sign #(.WIDTH(DATA_WIDTH)) u_abs_n (
        .i_value (dividend),
        .i_negate(dividend[DATA_WIDTH-1]),
        .o_value (w_abs_n)
    );

    div_abs_sign #(.WIDTH(DATA_WIDTH)) u_abs_d (
        .i_value (divisor),
        .i_negate(divisor[DATA_WIDTH-1]),
        .o_value (w_abs_d)
    );

    // One non-restoring step: shift {P,A}, add or subtract |D| by the sign of P, new quotient bit.
    assign w_d_ext   = {1'b0, r_d};
    assign w_p_shift = {r_p[DATA_WIDTH-1:0], r_a[DATA_WIDTH-1]};
    assign w_p_step  = r_p[DATA_WIDTH] ? (w_p_shift + w_d_ext) : (w_p_shift - w_d_ext);
    assign w_a_step  = {r_a[DATA_WIDTH-2:0], ~w_p_step[DATA_WIDTH]};

    // A negative final P lies in [-|D|, 0), so the corrected remainder fits in DATA_WIDTH bits.
    assign w_p_fix = r_p[DATA_WIDTH] ? (r_p[DATA_WIDTH-1:0] + r_d) : r_p[DATA_WIDTH-1:0];

    div_abs_sign #(.WIDTH(DATA_WIDTH)) u_sign_q (
        .i_value (r_a),
        .i_negate(r_sign_q),
        .o_value (w_q_signed)
    );

    div_abs_sign #(.WIDTH(DATA_WIDTH)) u_sign_r (
        .i_value (w_p_fix),
        .i_negate(r_sign_r),
        .o_value (w_r_signed)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = w_div_zero ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                busy = 1'b1;
                if (r_cnt == '0) begin
                    w_next = ST_FIX;
                end
            end
            ST_FIX: begin
                busy   = 1'b1;
                w_next = ST_DONE;
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_p         <= '0;
            r_a         <= '0;
            r_d         <= '0;
            r_cnt       <= '0;
            r_sign_q    <= 1'b0;
            r_sign_r    <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_sign_q    <= dividend[DATA_WIDTH-1] ^ divisor[DATA_WIDTH-1];
                        r_sign_r    <= dividend[DATA_WIDTH-1];
                        r_p         <= '0;
                        r_a         <= w_abs_n;
                        r_d         <= w_abs_d;
                        r_cnt       <= CW'(DATA_WIDTH - 1);
                        div_by_zero <= w_div_zero;
                        if (w_div_zero) begin
                            quotient  <= '1;
                            remainder <= dividend;
                        end
                    end
                end
                ST_CALC: begin
                    r_p   <= w_p_step;
                    r_a   <= w_a_step;
                    r_cnt <= r_cnt - CW'(1);
                end
                ST_FIX: begin
                    quotient  <= w_q_signed;
                    remainder <= w_r_signed;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
